// File: rtl/pll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_pkg
// Brief    : Shared PLL types, state encoding and default tuning constants.
// Revision : 1.0
// ============================================================================
package pll_pkg;

    localparam int FCW_W = 16;

    // Defaults for a 16-bit NCO phase accumulator clocked at 50 MHz.
    localparam logic [FCW_W-1:0] DEF_FCW_START    = 16'd262;
    localparam logic [FCW_W-1:0] DEF_FCW_STOP     = 16'd315;
    localparam logic [FCW_W-1:0] DEF_FCW_STEP     = 16'd1;
    localparam logic [23:0]      DEF_DWELL_CYC    = 24'd50000;
    localparam logic [15:0]      DEF_ACQ_THRESH   = 16'd2048;
    localparam logic [15:0]      DEF_LOCK_THRESH  = 16'd512;
    localparam logic [7:0]       DEF_LOCK_COUNT   = 8'd64;
    localparam logic [7:0]       DEF_UNLOCK_COUNT = 8'd16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWEEP  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_TRACK  = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    // |v| with the most negative code saturating instead of wrapping to itself.
    function automatic logic [15:0] abs_sat(input logic signed [15:0] v);
        logic [15:0] neg;
        neg = $unsigned(-v);
        if (v == 16'sh8000)
            return 16'h7FFF;
        else if (v < 16'sd0)
            return neg;
        else
            return $unsigned(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_acq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_acq_ctrl_if
// Brief    : Detector/loop-filter inputs and NCO/status outputs of the sequencer.
// Revision : 1.0
// ============================================================================
interface pll_acq_ctrl_if;
    import pll_pkg::*;

    logic             enable;
    logic [15:0]      phase_error;
    logic             pe_valid;
    logic [FCW_W-1:0] lf_freq_control;
    logic             lf_clear;
    logic [FCW_W-1:0] nco_freq_control;
    logic             locked;
    logic [2:0]       state;
    logic [7:0]       sweep_wraps;

    // master: system side feeding samples; slave: the acquisition sequencer
    modport master (
        output enable, phase_error, pe_valid, lf_freq_control,
        input  lf_clear, nco_freq_control, locked, state, sweep_wraps
    );

    modport slave (
        input  enable, phase_error, pe_valid, lf_freq_control,
        output lf_clear, nco_freq_control, locked, state, sweep_wraps
    );

endinterface
`default_nettype wire

// File: rtl/pll_lock_det.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_det
// Brief    : Phase-error magnitude and lock/unlock hysteresis counters.
// Revision : 1.0
// ============================================================================
module pll_lock_det
    import pll_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clr,
    input  wire logic [15:0] phase_error,
    input  wire logic        pe_valid,
    input  wire logic [15:0] lock_thresh,
    input  wire logic [7:0]  lock_count,
    input  wire logic [7:0]  unlock_count,
    output logic [15:0]      abs_pe,
    output logic             in_lock_hit,
    output logic             out_lock_hit
);

    logic [7:0] r_in_cnt;
    logic [7:0] r_out_cnt;
    logic       w_good;
    logic       w_in_full;
    logic       w_out_full;

    assign abs_pe = abs_sat(phase_error);
    assign w_good = (abs_pe < lock_thresh);

    // Hits fire on the sample that makes the count reach its target, so the
    // sequencer can change state on that very edge.
    assign w_in_full  = (({1'b0, r_in_cnt}  + 9'd1) >= {1'b0, lock_count});
    assign w_out_full = (({1'b0, r_out_cnt} + 9'd1) >= {1'b0, unlock_count});

    assign in_lock_hit  = pe_valid && !clr &&  w_good && w_in_full;
    assign out_lock_hit = pe_valid && !clr && !w_good && w_out_full;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_in_cnt  <= 8'd0;
            r_out_cnt <= 8'd0;
        end else if (pe_valid) begin
            if (w_good) begin
                if (r_in_cnt != 8'hFF)
                    r_in_cnt <= r_in_cnt + 8'd1;
                r_out_cnt <= 8'd0;
            end else begin
                r_in_cnt <= 8'd0;
                if (r_out_cnt != 8'hFF)
                    r_out_cnt <= r_out_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_acq_ctrl
// Brief    : PLL acquisition sweep, capture hand-off and lock sequencer.
// Revision : 1.0
// ============================================================================
module pll_acq_ctrl
    import pll_pkg::*;
#(
    parameter logic [FCW_W-1:0] FCW_START    = DEF_FCW_START,
    parameter logic [FCW_W-1:0] FCW_STOP     = DEF_FCW_STOP,
    parameter logic [FCW_W-1:0] FCW_STEP     = DEF_FCW_STEP,
    parameter logic [23:0]      DWELL_CYC    = DEF_DWELL_CYC,
    parameter logic [15:0]      ACQ_THRESH   = DEF_ACQ_THRESH,
    parameter logic [15:0]      LOCK_THRESH  = DEF_LOCK_THRESH,
    parameter logic [7:0]       LOCK_COUNT   = DEF_LOCK_COUNT,
    parameter logic [7:0]       UNLOCK_COUNT = DEF_UNLOCK_COUNT
)(
    input  wire logic      sys_clk,
    input  wire logic      reset,
    pll_acq_ctrl_if.slave  bus
);

    state_t           r_state;
    logic [FCW_W-1:0] r_base;
    logic [FCW_W-1:0] r_nco;
    logic [23:0]      r_dwell;
    logic             r_last_ok;
    logic             r_lf_clear;
    logic             r_locked;
    logic [7:0]       r_wraps;

    logic [15:0]        w_abs_pe;
    logic               w_in_hit;
    logic               w_out_hit;
    logic               w_det_clr;
    logic               w_acq_ok;
    logic               w_ok_now;
    logic               w_dwell_end;
    logic [FCW_W:0]     w_base_step;
    logic               w_step_over;
    logic signed [16:0] w_sum;
    logic [FCW_W-1:0]   w_nco_trk;

    // Counters run only while the loop filter is in control.
    assign w_det_clr = !((r_state == ST_TRACK) || (r_state == ST_LOCKED));

    pll_lock_det u_lock_det (
        .clk          (sys_clk),
        .rst          (reset),
        .clr          (w_det_clr),
        .phase_error  (bus.phase_error),
        .pe_valid     (bus.pe_valid),
        .lock_thresh  (LOCK_THRESH),
        .lock_count   (LOCK_COUNT),
        .unlock_count (UNLOCK_COUNT),
        .abs_pe       (w_abs_pe),
        .in_lock_hit  (w_in_hit),
        .out_lock_hit (w_out_hit)
    );

    assign w_acq_ok    = (w_abs_pe < ACQ_THRESH);
    // A sample landing on the last dwell cycle still counts for that dwell.
    assign w_ok_now    = bus.pe_valid ? w_acq_ok : r_last_ok;
    assign w_dwell_end = (r_dwell == (DWELL_CYC - 24'd1));
    assign w_base_step = {1'b0, r_base} + {1'b0, FCW_STEP};
    assign w_step_over = (w_base_step > {1'b0, FCW_STOP});

    assign w_sum = $signed({1'b0, r_base}) + $signed({bus.lf_freq_control[15], bus.lf_freq_control});

    always_comb begin
        w_nco_trk = w_sum[FCW_W-1:0];
        if (w_sum < $signed({1'b0, FCW_START}))
            w_nco_trk = FCW_START;
        else if (w_sum > $signed({1'b0, FCW_STOP}))
            w_nco_trk = FCW_STOP;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_base     <= FCW_START;
            r_nco      <= FCW_START;
            r_dwell    <= 24'd0;
            r_last_ok  <= 1'b0;
            r_lf_clear <= 1'b1;
            r_locked   <= 1'b0;
            r_wraps    <= 8'd0;
        end else if (!bus.enable) begin
            r_state    <= ST_IDLE;
            r_base     <= FCW_START;
            r_nco      <= FCW_START;
            r_dwell    <= 24'd0;
            r_last_ok  <= 1'b0;
            r_lf_clear <= 1'b1;
            r_locked   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_SWEEP;
                    r_base     <= FCW_START;
                    r_nco      <= FCW_START;
                    r_dwell    <= 24'd0;
                    r_last_ok  <= 1'b0;
                    r_lf_clear <= 1'b1;
                    r_wraps    <= 8'd0;
                end

                ST_SWEEP: begin
                    if (w_dwell_end) begin
                        r_dwell   <= 24'd0;
                        r_last_ok <= 1'b0;
                        if (w_ok_now) begin
                            r_state    <= ST_SETTLE;
                            r_lf_clear <= 1'b0;
                            r_nco      <= w_nco_trk;
                        end else if (w_step_over) begin
                            r_base <= FCW_START;
                            r_nco  <= FCW_START;
                            if (r_wraps != 8'hFF)
                                r_wraps <= r_wraps + 8'd1;
                        end else begin
                            r_base <= w_base_step[FCW_W-1:0];
                            r_nco  <= w_base_step[FCW_W-1:0];
                        end
                    end else begin
                        r_dwell <= r_dwell + 24'd1;
                        if (bus.pe_valid)
                            r_last_ok <= w_acq_ok;
                    end
                end

                ST_SETTLE: begin
                    r_nco <= w_nco_trk;
                    if (w_dwell_end) begin
                        r_state <= ST_TRACK;
                        r_dwell <= 24'd0;
                    end else begin
                        r_dwell <= r_dwell + 24'd1;
                    end
                end

                ST_TRACK: begin
                    if (w_out_hit) begin
                        r_state    <= ST_SWEEP;
                        r_base     <= FCW_START;
                        r_nco      <= FCW_START;
                        r_dwell    <= 24'd0;
                        r_last_ok  <= 1'b0;
                        r_lf_clear <= 1'b1;
                    end else begin
                        r_nco <= w_nco_trk;
                        if (w_in_hit) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (w_out_hit) begin
                        r_state    <= ST_SWEEP;
                        r_base     <= FCW_START;
                        r_nco      <= FCW_START;
                        r_dwell    <= 24'd0;
                        r_last_ok  <= 1'b0;
                        r_lf_clear <= 1'b1;
                        r_locked   <= 1'b0;
                    end else begin
                        r_nco <= w_nco_trk;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.lf_clear         = r_lf_clear;
    assign bus.nco_freq_control = r_nco;
    assign bus.locked           = r_locked;
    assign bus.state            = r_state;
    assign bus.sweep_wraps      = r_wraps;

endmodule
`default_nettype wire

// File: tb/tb_pll_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_acq_ctrl
// Brief    : Directed self-checking bench for pll_acq_ctrl (dwell shortened).
// Revision : 1.0
// ============================================================================
module tb_pll_acq_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int unsigned sb_q[$];

    pll_acq_ctrl_if bus ();

    pll_acq_ctrl #(
        .DWELL_CYC (24'd10)
    ) dut (
        .sys_clk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int unsigned v);
        sb_q.push_back(v);
    endtask

    task automatic check(input string tag, input int unsigned obs);
        int unsigned exp;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=<empty scoreboard>", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
        end
    endtask

    task automatic sample(input logic [15:0] pe);
        bus.phase_error = pe;
        bus.pe_valid    = 1'b1;
        tick();
        bus.pe_valid    = 1'b0;
    endtask

    task automatic wait_state(input string tag, input int unsigned target, input int budget);
        expect_val(target);
        for (int i = 0; i < budget; i++) begin
            if (bus.state == 3'(target))
                break;
            tick();
        end
        check(tag, bus.state);
    endtask

    initial begin
        n_checks            = 0;
        n_fail              = 0;
        reset               = 1'b1;
        bus.enable          = 1'b0;
        bus.phase_error     = 16'd0;
        bus.pe_valid        = 1'b0;
        bus.lf_freq_control = 16'd0;

        // Reset and idle
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        expect_val(0);   check("idle_state", bus.state);
        expect_val(262); check("idle_nco", bus.nco_freq_control);
        expect_val(1);   check("idle_lf_clear", bus.lf_clear);
        expect_val(0);   check("idle_locked", bus.locked);
        expect_val(0);   check("idle_wraps", bus.sweep_wraps);

        // Full sweep with a large error, then wrap
        bus.enable      = 1'b1;
        bus.phase_error = 16'd4000;
        bus.pe_valid    = 1'b1;
        tick();
        expect_val(1); check("sweep_state", bus.state);
        for (int b = 262; b <= 315; b++) begin
            expect_val(b); check("sweep_nco", bus.nco_freq_control);
            repeat (10) tick();
        end
        expect_val(262); check("wrap_nco", bus.nco_freq_control);
        expect_val(1);   check("wrap_count", bus.sweep_wraps);

        // Capture at base 280
        for (int b = 262; b < 280; b++) repeat (10) tick();
        expect_val(280); check("pre_capture_nco", bus.nco_freq_control);
        bus.phase_error     = 16'd100;
        bus.lf_freq_control = 16'd5;
        repeat (10) tick();
        bus.pe_valid = 1'b0;
        expect_val(2);   check("settle_state", bus.state);
        expect_val(0);   check("settle_lf_clear", bus.lf_clear);
        expect_val(285); check("settle_nco_plus5", bus.nco_freq_control);
        bus.lf_freq_control = 16'hFF00;
        tick();
        expect_val(262); check("settle_clamp_low", bus.nco_freq_control);
        bus.lf_freq_control = 16'd100;
        tick();
        expect_val(315); check("settle_clamp_high", bus.nco_freq_control);
        bus.lf_freq_control = 16'd0;
        tick();
        expect_val(280); check("settle_nco_zero", bus.nco_freq_control);
        wait_state("enter_track", 3, 20);

        // Lock with one bad sample at count 63
        repeat (63) sample(16'd100);
        sample(16'd600);
        repeat (63) sample(16'd100);
        expect_val(3); check("track_after_restart", bus.state);
        expect_val(0); check("track_not_locked", bus.locked);
        sample(16'd100);
        expect_val(4); check("lock_state", bus.state);
        expect_val(1); check("lock_flag", bus.locked);

        // Unlock hysteresis
        repeat (15) sample(16'd600);
        sample(16'd100);
        expect_val(1); check("hyst_locked", bus.locked);
        expect_val(4); check("hyst_state", bus.state);
        repeat (15) sample(16'd600);
        expect_val(1); check("unlock_15_locked", bus.locked);
        sample(16'd600);
        expect_val(0);   check("unlock_locked", bus.locked);
        expect_val(1);   check("unlock_state", bus.state);
        expect_val(262); check("unlock_nco", bus.nco_freq_control);
        expect_val(1);   check("unlock_lf_clear", bus.lf_clear);

        // Recapture at 262, then most-negative error breaks the lock run
        bus.phase_error = 16'd100;
        bus.pe_valid    = 1'b1;
        wait_state("recapture", 2, 40);
        bus.pe_valid = 1'b0;
        expect_val(262); check("recapture_nco", bus.nco_freq_control);
        wait_state("retrack", 3, 40);
        repeat (63) sample(16'd100);
        sample(16'h8000);
        expect_val(3); check("minneg_state", bus.state);
        repeat (63) sample(16'd100);
        expect_val(3); check("minneg_restart", bus.state);
        sample(16'd100);
        expect_val(4); check("relock_state", bus.state);

        // Enable dropped while locked
        bus.enable = 1'b0;
        tick();
        expect_val(0);   check("disable_state", bus.state);
        expect_val(0);   check("disable_locked", bus.locked);
        expect_val(262); check("disable_nco", bus.nco_freq_control);
        expect_val(1);   check("disable_lf_clear", bus.lf_clear);

        // Reset mid-SETTLE
        bus.enable = 1'b1;
        tick();
        expect_val(1); check("reenable_state", bus.state);
        expect_val(0); check("reenable_wraps", bus.sweep_wraps);
        bus.phase_error = 16'd100;
        bus.pe_valid    = 1'b1;
        wait_state("settle_again", 2, 40);
        bus.pe_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        expect_val(0);   check("rst_state", bus.state);
        expect_val(262); check("rst_nco", bus.nco_freq_control);
        expect_val(1);   check("rst_lf_clear", bus.lf_clear);
        expect_val(0);   check("rst_locked", bus.locked);
        expect_val(0);   check("rst_wraps", bus.sweep_wraps);
        reset      = 1'b0;
        bus.enable = 1'b0;
        tick();
        expect_val(0); check("post_rst_idle", bus.state);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
